// File: rtl/div_nat_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_nat_seq_if
//  Purpose  : soc/eoc handshake bundle for the sequential natural divider.
//             master = operand producer, slave = divider.
//  Revision : 1.0  initial release
// ============================================================================
interface div_nat_seq_if #(
    parameter int N = 8
);
    logic         soc;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         eoc;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;

    modport master (output soc, x, y, input  eoc, q, r, dz);
    modport slave  (input  soc, x, y, output eoc, q, r, dz);
endinterface
`default_nettype wire

// File: rtl/div_nat_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_nat_seq
//  Purpose  : Sequential restoring divider for naturals, N-bit / N-bit.
//             One shift-subtract step per clock, N+1 cycles per operation,
//             soc/eoc handshake. Divide-by-zero runs the normal algorithm
//             and yields q = all ones, r = x, dz = 1.
//  Revision : 1.0  initial release
// ============================================================================
module div_nat_seq #(
    parameter int N = 8
) (
    input  wire logic       clock,
    input  wire logic       reset,
    div_nat_seq_if.slave    bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_END  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N:0]    rem_q,   rem_d;     // partial remainder, one guard bit
    logic [N-1:0]  quo_q,   quo_d;     // dividend shifting out / quotient shifting in
    logic [N-1:0]  div_q,   div_d;     // captured divisor
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          dzw_q,   dzw_d;     // divide-by-zero of the running operation
    logic [N-1:0]  q_q,     q_d;
    logic [N-1:0]  r_q,     r_d;
    logic          dz_q,    dz_d;
    logic          eoc_q,   eoc_d;

    logic [N:0]    rem_sh;
    logic [N:0]    trial;
    logic          no_borrow;

    // Combinational subtract/compare: difference and "minuend >= subtrahend".
    // The guard bit of the remainder never sets for legal operands; if it
    // did, the shifted value would exceed any divisor, hence the OR.
    always_comb begin
        rem_sh    = {rem_q[N-1:0], quo_q[N-1]};
        trial     = rem_sh - {1'b0, div_q};
        no_borrow = rem_q[N] | (rem_sh >= {1'b0, div_q});
    end

    // Next-state: load, one restoring step per cycle, result commit, END wait.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        dzw_d   = dzw_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.soc) begin
                    rem_d   = '0;
                    quo_d   = bus.x;
                    div_d   = bus.y;
                    cnt_d   = '0;
                    dzw_d   = (bus.y == '0);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rem_d = no_borrow ? trial : rem_sh;
                quo_d = {quo_q[N-2:0], no_borrow};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    q_d     = quo_d;
                    r_d     = rem_d[N-1:0];
                    dz_d    = dzw_q;
                    // soc still high means this request is already served
                    state_d = bus.soc ? S_END : S_IDLE;
                end
            end
            S_END: begin
                if (!bus.soc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        eoc_d = (state_d != S_CALC);
    end

    // State and datapath registers with synchronous reset; aborts drop the result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            dzw_q   <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            eoc_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            dzw_q   <= dzw_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            eoc_q   <= eoc_d;
        end
    end

    assign bus.eoc = eoc_q;
    assign bus.q   = q_q;
    assign bus.r   = r_q;
    assign bus.dz  = dz_q;
endmodule
`default_nettype wire

// File: tb/tb_div_nat_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_nat_seq
//  Purpose  : Self-checking bench for div_nat_seq, one N=8 and one N=5
//             instance, compared every cycle against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_nat_seq;
    logic clock;
    logic reset;

    logic       soc_v [2];
    logic [7:0] x_v   [2];
    logic [7:0] y_v   [2];
    logic       eoc_v [2];
    logic [7:0] q_v   [2];
    logic [7:0] r_v   [2];
    logic       dz_v  [2];

    int tests = 0;
    int fails = 0;

    div_nat_seq_if #(.N(8)) if8 ();
    div_nat_seq_if #(.N(5)) if5 ();

    assign if8.soc = soc_v[0];
    assign if8.x   = x_v[0];
    assign if8.y   = y_v[0];
    assign if5.soc = soc_v[1];
    assign if5.x   = x_v[1][4:0];
    assign if5.y   = y_v[1][4:0];
    assign eoc_v[0] = if8.eoc;
    assign q_v[0]   = if8.q;
    assign r_v[0]   = if8.r;
    assign dz_v[0]  = if8.dz;
    assign eoc_v[1] = if5.eoc;
    assign q_v[1]   = {3'b000, if5.q};
    assign r_v[1]   = {3'b000, if5.r};
    assign dz_v[1]  = if5.dz;

    div_nat_seq #(.N(8)) u_dut8 (.clock(clock), .reset(reset), .bus(if8.slave));
    div_nat_seq #(.N(5)) u_dut5 (.clock(clock), .reset(reset), .bus(if5.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int nw(input int k);
        return (k == 0) ? 8 : 5;
    endfunction

    function automatic logic [7:0] msk(input int k);
        return (k == 0) ? 8'hFF : 8'h1F;
    endfunction

    // ---------------- behavioural model (per instance) ----------------
    bit         started = 0;
    bit         m_busy [2] = '{0, 0};
    bit         m_hold [2] = '{0, 0};
    int         m_left [2] = '{0, 0};
    logic [7:0] m_x    [2] = '{8'd0, 8'd0};
    logic [7:0] m_y    [2] = '{8'd0, 8'd0};
    logic [7:0] m_q    [2] = '{8'd0, 8'd0};
    logic [7:0] m_r    [2] = '{8'd0, 8'd0};
    bit         m_dz   [2] = '{0, 0};

    always @(posedge clock) begin
        started = 1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_busy[k] = 0; m_hold[k] = 0; m_left[k] = 0;
                m_q[k] = 8'd0; m_r[k] = 8'd0; m_dz[k] = 0;
            end else if (m_busy[k]) begin
                m_left[k] = m_left[k] - 1;
                if (m_left[k] == 0) begin
                    m_busy[k] = 0;
                    m_hold[k] = soc_v[k];
                    if (m_y[k] == 8'd0) begin
                        m_q[k] = msk(k); m_r[k] = m_x[k]; m_dz[k] = 1;
                    end else begin
                        m_q[k] = m_x[k] / m_y[k]; m_r[k] = m_x[k] % m_y[k]; m_dz[k] = 0;
                    end
                end
            end else if (m_hold[k]) begin
                if (!soc_v[k]) m_hold[k] = 0;
            end else if (soc_v[k]) begin
                m_busy[k] = 1;
                m_left[k] = nw(k);
                m_x[k] = x_v[k] & msk(k);
                m_y[k] = y_v[k] & msk(k);
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (eoc_v[k] !== !m_busy[k] || q_v[k] !== m_q[k] ||
                    r_v[k] !== m_r[k] || dz_v[k] !== m_dz[k]) begin
                    fails++;
                    $display("FAIL model_cmp n%0d t=%0t: eoc=%0b q=%0d r=%0d dz=%0b, expected eoc=%0b q=%0d r=%0d dz=%0b",
                             nw(k), $time, eoc_v[k], q_v[k], r_v[k], dz_v[k],
                             !m_busy[k], m_q[k], m_r[k], m_dz[k]);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Issue one request with soc high for 'hold' cycles; returns the number of
    // sampled cycles eoc was low (or -1 if completion never arrived).
    task automatic run_op(input int k, input logic [7:0] xa, input logic [7:0] ya,
                          input int hold, output int lat);
        int low;
        bit done;
        @(negedge clock);
        soc_v[k] = 1'b1; x_v[k] = xa; y_v[k] = ya;
        low = 0; done = 0;
        for (int i = 1; i <= 60 && !done; i++) begin
            @(negedge clock);
            if (i == hold) soc_v[k] = 1'b0;
            x_v[k] = 8'($urandom);
            y_v[k] = 8'($urandom);
            if (eoc_v[k] == 1'b0) low++;
            else if (low > 0 && i >= hold) done = 1;
        end
        lat = done ? low : -1;
    endtask

    task automatic rand_ops(input int k, input int n);
        int lat, hold;
        logic [7:0] xa, ya;
        for (int i = 0; i < n; i++) begin
            xa = 8'($urandom) & msk(k);
            ya = ($urandom_range(0, 15) == 0) ? 8'd0 : (8'($urandom) & msk(k));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : 1;
            run_op(k, xa, ya, hold, lat);
            chk($sformatf("lat_rand_n%0d", nw(k)), lat, nw(k));
        end
    endtask

    int bx [4] = '{255, 5, 0, 255};
    int by [4] = '{1, 9, 3, 255};
    int bq [4] = '{255, 0, 0, 1};
    int br [4] = '{0, 5, 0, 0};

    initial begin
        int lat;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            soc_v[k] = 1'b0; x_v[k] = 8'd0; y_v[k] = 8'd0;
        end
        repeat (3) @(negedge clock);
        chk("rst_eoc", int'(eoc_v[0]), 1);
        chk("rst_q", int'(q_v[0]), 0);
        chk("rst_r", int'(r_v[0]), 0);
        chk("rst_dz", int'(dz_v[0]), 0);
        reset = 1'b0;

        run_op(0, 8'd100, 8'd7, 1, lat);
        chk("lat_100_7", lat, 8);
        chk("q_100_7", int'(q_v[0]), 14);
        chk("r_100_7", int'(r_v[0]), 2);
        chk("dz_100_7", int'(dz_v[0]), 0);
        chk("eoc_100_7", int'(eoc_v[0]), 1);

        for (int i = 0; i < 4; i++) begin
            run_op(0, 8'(bx[i]), 8'(by[i]), 1, lat);
            chk($sformatf("q_bnd%0d", i), int'(q_v[0]), bq[i]);
            chk($sformatf("r_bnd%0d", i), int'(r_v[0]), br[i]);
        end

        run_op(0, 8'd77, 8'd0, 1, lat);
        chk("lat_dz", lat, 8);
        chk("q_dz", int'(q_v[0]), 255);
        chk("r_dz", int'(r_v[0]), 77);
        chk("dz_dz", int'(dz_v[0]), 1);
        run_op(0, 8'd9, 8'd3, 1, lat);
        chk("q_9_3", int'(q_v[0]), 3);
        chk("r_9_3", int'(r_v[0]), 0);
        chk("dz_9_3", int'(dz_v[0]), 0);

        run_op(0, 8'd50, 8'd6, 20, lat);
        chk("lat_hold", lat, 8);
        chk("q_hold", int'(q_v[0]), 8);
        chk("r_hold", int'(r_v[0]), 2);
        run_op(0, 8'd1, 8'd1, 1, lat);
        chk("q_after_hold", int'(q_v[0]), 1);
        chk("lat_after_hold", lat, 8);

        // Abort after the third step edge.
        @(negedge clock);
        soc_v[0] = 1'b1; x_v[0] = 8'd200; y_v[0] = 8'd3;
        @(negedge clock);
        soc_v[0] = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_eoc", int'(eoc_v[0]), 1);
        chk("abort_q", int'(q_v[0]), 0);
        chk("abort_r", int'(r_v[0]), 0);
        chk("abort_dz", int'(dz_v[0]), 0);

        run_op(0, 8'd200, 8'd3, 1, lat);
        chk("q_200_3", int'(q_v[0]), 66);
        chk("r_200_3", int'(r_v[0]), 2);

        fork
            rand_ops(0, 1000);
            rand_ops(1, 1000);
        join

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
